// File: rtl/fp_pkg.sv
// Shared binary32 constants, converter state encoding and field packing helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fp_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  // Assemble {sign, exponent, mantissa} into a binary32 word.
  function automatic logic [31:0] fp32_pack(
    input logic                  sign,
    input logic [FP32_EXP_W-1:0] exp,
    input logic [FP32_MAN_W-1:0] man
  );
    return {sign, exp, man};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized 23-bit mantissa with guard/sticky bits.
// Latency: purely combinational.
// Backpressure: none; the caller owns all handshaking.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP32_MAN_W-1:0] man,
  input  logic [FP32_EXP_W-1:0] exp,
  input  logic                  guard,
  input  logic                  sticky,
  output logic [FP32_MAN_W-1:0] man_r,
  output logic [FP32_EXP_W-1:0] exp_r,
  output logic                  inexact
);

  logic              round_up;
  logic [FP32_MAN_W:0] man_inc;

  // Increment on more-than-half, or on an exact tie when the mantissa is odd.
  // A carry out of the mantissa leaves it zero and bumps the exponent.
  always_comb begin
    round_up = guard & (sticky | man[0]);
    man_inc  = {1'b0, man} + {{FP32_MAN_W{1'b0}}, round_up};
    man_r    = man_inc[FP32_MAN_W-1:0];
    exp_r    = exp + {{(FP32_EXP_W-1){1'b0}}, man_inc[FP32_MAN_W]};
    inexact  = guard | sticky;
  end

endmodule

// File: rtl/int_to_fp_converter.sv
// Converts a signed/unsigned 32-bit integer to IEEE-754 binary32 (RNE rounding).
// Latency: 1 cycle for zero, else 3 + NORM shift cycles from accept to out_valid.
// Backpressure: one transaction in flight; in_ready low until out_valid && out_ready.
module int_to_fp_converter
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 1  // 1, 2, 4 or 8 bits per normalization cycle
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  // Exponent of a value whose leading one sits at bit 31.
  localparam logic [FP32_EXP_W-1:0] EXP_TOP = FP32_EXP_W'(FP32_BIAS + 31);
  localparam logic [4:0]            LZ_STEP = 5'(SHIFT_STEP);

  conv_state_e state, state_nxt;

  logic [31:0] mag;
  logic [4:0]  lz;
  logic        sign;

  logic        in_sign;
  logic [31:0] in_mag;
  logic        in_zero;

  logic [FP32_MAN_W-1:0] rnd_man_r;
  logic [FP32_EXP_W-1:0] rnd_exp;
  logic [FP32_EXP_W-1:0] rnd_exp_r;
  logic                  rnd_inexact;

  // Magnitude of the incoming operand; -0x80000000 naturally wraps to 0x80000000.
  always_comb begin
    in_sign = in_signed & in_data[31];
    in_mag  = in_sign ? (~in_data + 32'd1) : in_data;
    in_zero = (in_mag == 32'd0);
    rnd_exp = EXP_TOP - {3'b000, lz};
  end

  fp_round_rne u_round (
    .man     (mag[30:8]),
    .exp     (rnd_exp),
    .guard   (mag[7]),
    .sticky  (|mag[6:0]),
    .man_r   (rnd_man_r),
    .exp_r   (rnd_exp_r),
    .inexact (rnd_inexact)
  );

  // State register; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_zero ? DONE : NORM;
      end
      NORM: begin
        if (mag[31]) state_nxt = ROUND;
      end
      ROUND: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift toward bit 31 in NORM, register the
  // rounded result in ROUND. Results hold until the next conversion lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag         <= 32'd0;
      lz          <= 5'd0;
      sign        <= 1'b0;
      out_data    <= 32'd0;
      out_inexact <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_sign;
            mag  <= in_mag;
            lz   <= 5'd0;
            if (in_zero) begin
              out_data    <= 32'd0;
              out_inexact <= 1'b0;
            end
          end
        end
        NORM: begin
          if (!mag[31]) begin
            // A full step is only taken when all its bits are zero, so the
            // leading one can never be shifted past bit 31.
            if (mag[31 -: SHIFT_STEP] == '0) begin
              mag <= mag << SHIFT_STEP;
              lz  <= lz + LZ_STEP;
            end else begin
              mag <= mag << 1;
              lz  <= lz + 5'd1;
            end
          end
        end
        ROUND: begin
          out_data    <= fp32_pack(sign, rnd_exp_r, rnd_man_r);
          out_inexact <= rnd_inexact;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Self-checking bench: directed and random conversions on SHIFT_STEP=1 and 4 instances.
// Latency: measured per transaction against an arithmetic reference.
// Backpressure: exercises out_ready stalls, back-to-back accepts and mid-flight reset.
module tb_int_to_fp_converter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0: SHIFT_STEP=1 instance, index 1: SHIFT_STEP=4 instance.
  logic        iv   [2];
  logic        ir   [2];
  logic [31:0] id   [2];
  logic        isg  [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [31:0] od   [2];
  logic        oi   [2];

  int errors = 0;
  int checks = 0;

  int_to_fp_converter #(.SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_signed(isg[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_inexact(oi[0])
  );

  int_to_fp_converter #(.SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_signed(isg[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_inexact(oi[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer value, rounded to 24 significant bits by
  // remainder comparison against one half ulp.
  task automatic model(input logic [31:0] d, input logic s, input int step,
                       output logic [31:0] r, output logic inx, output int lat);
    logic neg;
    logic [63:0] v, q, rem, half;
    int p, sh, e, lz;
    neg = s && d[31];
    v   = neg ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
    if (v == 64'd0) begin
      r = 32'd0; inx = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    lz  = 31 - p;
    lat = 3 + lz / step + lz % step;
    e   = 127 + p;
    if (p <= 23) begin
      q   = v << (23 - p);
      inx = 1'b0;
    end else begin
      sh   = p - 23;
      q    = v >> sh;
      rem  = v - (q << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    r = {neg, 8'(e), q[22:0]};
  endtask

  // One full transaction on instance sel; called with time just after a posedge.
  task automatic run(input int sel, input logic [31:0] d, input logic s, input int hold,
                     output logic [31:0] got_d, output logic got_i, output int lat);
    logic [31:0] exp_d;
    logic        exp_i;
    int          exp_lat;
    int          w;
    model(d, s, (sel == 0) ? 1 : 4, exp_d, exp_i, exp_lat);
    id[sel] = d; isg[sel] = s; iv[sel] = 1'b1;
    w = 0;
    while (!ir[sel] && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_wait", 32'(w < 100), 32'd1);
    @(posedge clk); #1;
    iv[sel] = 1'b0; id[sel] = $urandom; isg[sel] = 1'($urandom);
    lat = 1;
    while (!ov[sel] && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    got_d = od[sel];
    got_i = oi[sel];
    chk($sformatf("lat[%0d] %h", sel, d), 32'(lat), 32'(exp_lat));
    chk($sformatf("data[%0d] %h s%0d", sel, d, s), got_d, exp_d);
    chk($sformatf("inexact[%0d] %h", sel, d), 32'(got_i), 32'(exp_i));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_data", od[sel], got_d);
      chk("hold_valid", 32'(ov[sel]), 32'd1);
      chk("hold_in_ready", 32'(ir[sel]), 32'd0);
    end
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    chk("post_hs_in_ready", 32'(ir[sel]), 32'd1);
    chk("post_hs_valid", 32'(ov[sel]), 32'd0);
  endtask

  logic [31:0] dv [7] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                          32'h00000000, 32'h01000001, 32'h01000003};
  logic        ds [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] de [7] = '{32'h3F800000, 32'hBF800000, 32'h4F800000, 32'hCF000000,
                          32'h00000000, 32'h4B800000, 32'h4B800002};
  logic        di [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gd;
    logic        gi;
    int          lat;
    logic [31:0] rd;

    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; id[i] = 32'd0; isg[i] = 1'b0; ordy[i] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 32'(ir[i]), 32'd1);
      chk("rst_out_valid", 32'(ov[i]), 32'd0);
      chk("rst_out_data", od[i], 32'd0);
      chk("rst_out_inexact", 32'(oi[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on both instances, checked against literal results too.
    for (int sel = 0; sel < 2; sel++) begin
      for (int t = 0; t < 7; t++) begin
        run(sel, dv[t], ds[t], 0, gd, gi, lat);
        chk($sformatf("dir_data[%0d] #%0d", sel, t), gd, de[t]);
        chk($sformatf("dir_inexact[%0d] #%0d", sel, t), 32'(gi), 32'(di[t]));
        if (sel == 0 && t == 0) chk("dir_lat_one", 32'(lat), 32'd34);
        if (t == 4)             chk("dir_lat_zero", 32'(lat), 32'd1);
      end
    end

    // Output stall, then back-to-back accept straight after the handshake.
    run(0, 32'h12345678, 1'b0, 5, gd, gi, lat);
    run(0, 32'h87654321, 1'b1, 0, gd, gi, lat);

    // Randomized operands of varied magnitude and signedness.
    for (int n = 0; n < 30; n++) begin
      for (int sel = 0; sel < 2; sel++) begin
        rd = $urandom;
        if ($urandom_range(0, 1) == 1) rd = rd >> $urandom_range(0, 31);
        run(sel, rd, 1'($urandom), $urandom_range(0, 2), gd, gi, lat);
      end
    end

    // Reset while normalizing: leave a nonzero prior result, then start a
    // long conversion and drop reset partway through.
    run(0, 32'h00ABCDEF, 1'b0, 0, gd, gi, lat);
    id[0] = 32'd1; isg[0] = 1'b1; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(ir[0]), 32'd1);
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_out_data", od[0], 32'd0);
    chk("midrst_out_inexact", 32'(oi[0]), 32'd0);
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("postrst_valid", 32'(ov[0]), 32'd0);
    end
    chk("postrst_in_ready", 32'(ir[0]), 32'd1);
    run(0, 32'h00000001, 1'b1, 0, gd, gi, lat);
    run(1, 32'hFFFFFFFF, 1'b0, 1, gd, gi, lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
